magma_encoder: RTL and testbench

Fully pipelined 128-bit block encryptor implementing the GOST R 34.12-2015 "Kuznyechik" cipher: 10 rounds, 256-bit key, key expansion performed in-pipeline. Each cycle it accepts one plaintext block and its key, and returns the ciphertext a fixed 128 cycles later. It sits in the crypto datapath as a streaming stage with no handshake; the surrounding logic tracks data validity by counting cycles.

---
 rtl/magma_encoder.sv | 145 ++++++++++++++
 tb/tb_magma_encoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/magma_encoder.sv
// magma_encoder: streaming Kuznyechik (GOST R 34.12-2015) block encryptor.
// Round keys are expanded alongside each block; fixed 128-cycle latency.
module magma_encoder (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] block,
  input  logic [255:0] key,
  output logic [127:0] encoded
);

  // pi[0] sits in the top byte
  localparam logic [2047:0] PI = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D,
    128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F,
    128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC,
    128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1,
    128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903,
    128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641,
    128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789,
    128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52,
    128'h59A674D2E6F4B4C0D166AFC2394B63B6
  };

  // byte i holds the l() coefficient of a_i
  localparam logic [127:0] LC =
    128'h94208510C2C001FB01C0C21085209401;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'hC3 : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] s_layer(
    input logic [127:0] a
  );
    logic [127:0] s;
    logic [10:0]  ix;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      ix = {~a[8*i +: 8], 3'b000};
      s[8*i +: 8] = PI[ix +: 8];
    end
    return s;
  endfunction

  function automatic logic [127:0] r_step(
    input logic [127:0] a
  );
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 16; i++)
      t = t ^ gmul(a[8*i +: 8], LC[8*i +: 8]);
    return {t, a[127:8]};
  endfunction

  function automatic logic [127:0] l_layer(
    input logic [127:0] a
  );
    logic [127:0] x;
    x = a;
    for (int i = 0; i < 16; i++) x = r_step(x);
    return x;
  endfunction

  function automatic logic [127:0] lsx(
    input logic [127:0] a,
    input logic [127:0] k
  );
    return l_layer(s_layer(a ^ k));
  endfunction

  logic [127:0] d_q  [1:127];
  logic [127:0] ka_q [1:33];
  logic [127:0] kb_q [1:33];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q[1]  <= '0;
      ka_q[1] <= '0;
      kb_q[1] <= '0;
    end else begin
      d_q[1]  <= block;
      ka_q[1] <= key[255:128];
      kb_q[1] <= key[127:0];
    end
  end

  // one Feistel step per stage; (K2j+1, K2j+2) land in stage 8j+1
  for (genvar s = 2; s <= 33; s++) begin : g_key
    localparam logic [127:0] C = l_layer(128'(s - 1));
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ka_q[s] <= '0;
        kb_q[s] <= '0;
      end else begin
        ka_q[s] <= lsx(ka_q[s-1], C) ^ kb_q[s-1];
        kb_q[s] <= ka_q[s-1];
      end
    end
  end

  for (genvar s = 2; s <= 127; s++) begin : g_data
    logic [127:0] nxt;
    if (s == 2 || s == 10 || s == 18 || s == 26) begin : g_rnd
      assign nxt = lsx(lsx(d_q[s-1], ka_q[s-1]), kb_q[s-1]);
    end else if (s == 34) begin : g_fin
      assign nxt = lsx(d_q[s-1], ka_q[s-1]) ^ kb_q[s-1];
    end else begin : g_dly
      assign nxt = d_q[s-1];
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) d_q[s] <= '0;
      else      d_q[s] <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) encoded <= '0;
    else      encoded <= d_q[127];
  end

endmodule

// File: tb/tb_magma_encoder.sv
// tb_magma_encoder: vector table, corner sequences and random streaming
// checked against a byte-level Kuznyechik reference model.
module tb_magma_encoder;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic [127:0] block = '0;
  logic [255:0] key   = '0;
  logic [127:0] encoded;

  magma_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .block   (block),
    .key     (key),
    .encoded (encoded)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] GK =
    256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] GB = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] GC = 128'h7f679d90bebc24305a468d42b9d4edcd;

  typedef struct {
    logic [127:0] exp;
    string        nm;
  } slot_t;

  typedef struct {
    logic [255:0] k;
    logic [127:0] b;
    logic [127:0] exp;
    string        nm;
  } vec_t;

  slot_t        hist [$];
  vec_t         vecs [8];
  int           n_chk  = 0;
  int           n_fail = 0;
  logic [7:0]   sb   [256];
  logic [7:0]   mt   [256][256];
  logic [7:0]   coef [16];
  logic [127:0] cst  [64];
  logic [127:0] zexp;
  logic [255:0] rk_v;
  logic [127:0] rb_v;

  // carry-less product, then polynomial long division by 0x1C3
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'(9'h1C3) << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] lin(input logic [127:0] v);
    logic [7:0]   a [16];
    logic [7:0]   t;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = v[8*i +: 8];
    for (int n = 0; n < 16; n++) begin
      t = '0;
      for (int j = 0; j < 16; j++) t = t ^ mt[coef[j]][a[j]];
      for (int i = 0; i < 15; i++) a[i] = a[i+1];
      a[15] = t;
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = a[i];
    return r;
  endfunction

  function automatic logic [127:0] sub(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[v[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [255:0] k, input logic [127:0] b);
    logic [127:0] rk [16];
    logic [127:0] a1, a0, t, x;
    rk[1] = k[255:128];
    rk[2] = k[127:0];
    for (int j = 1; j <= 4; j++) begin
      a1 = rk[4'(2*j-1)];
      a0 = rk[4'(2*j)];
      for (int i = 8*j-7; i <= 8*j; i++) begin
        t  = lin(sub(a1 ^ cst[6'(i)])) ^ a0;
        a0 = a1;
        a1 = t;
      end
      rk[4'(2*j+1)] = a1;
      rk[4'(2*j+2)] = a0;
    end
    x = b;
    for (int r = 1; r <= 9; r++) x = lin(sub(x ^ rk[4'(r)]));
    return x ^ rk[10];
  endfunction

  function automatic logic [127:0] rot(input logic [127:0] b, input int n);
    logic [127:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[119:0], r[127:120]};
    return r;
  endfunction

  task automatic init_model();
    logic [2047:0] v;
    v = {
      128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
      128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
      128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
      128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
      128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
      128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
      128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
      128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };
    for (int i = 0; i < 256; i++) begin
      sb[8'(i)] = v[2047:2040];
      v = v << 8;
    end
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        mt[8'(a)][8'(b)] = gmul(8'(a), 8'(b));
    coef = '{8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
             8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148};
    for (int i = 1; i <= 32; i++) cst[6'(i)] = lin(128'(i));
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: encoded=%h required=%h", nm, act, req);
    end
  endtask

  // drive one slot; compare the slot sampled 127 edges earlier
  task automatic tick(input logic [255:0] k, input logic [127:0] b,
                      input logic [127:0] exp, input string nm);
    slot_t s;
    key   = k;
    block = b;
    @(posedge clk);
    #1;
    s.exp = exp;
    s.nm  = nm;
    hist.push_back(s);
    if (hist.size() == 128) begin
      s = hist.pop_front();
      check(s.nm, encoded, s.exp);
    end
  endtask

  task automatic rand_vec();
    rk_v = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
    rb_v = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  initial begin
    init_model();
    zexp = model('0, '0);

    #12;
    check("reset_state", encoded, '0);
    #8;
    rst = 1'b1;

    for (int i = 0; i < 4; i++) tick('0, '0, zexp, "lat_pre");
    tick(GK, GB, GC, "lat_gost");
    for (int i = 0; i < 4; i++) tick('0, '0, zexp, "lat_post");

    vecs[0] = '{GK, GB, GC, "stream_gost"};
    vecs[1] = '{GK, rot(GB, 1), model(GK, rot(GB, 1)), "stream_rot1"};
    vecs[2] = '{GK, rot(GB, 2), model(GK, rot(GB, 2)), "stream_rot2"};
    vecs[3] = '{256'h0, GB, model('0, GB), "alt_zero_key"};
    vecs[4] = '{GK, GB, GC, "alt_gost_key"};
    vecs[5] = '{256'h0, GB, model('0, GB), "alt_zero_key"};
    vecs[6] = '{GK, GB, GC, "alt_gost_key"};
    vecs[7] = '{256'h0, GB, model('0, GB), "alt_zero_key"};
    for (int i = 0; i < 8; i++)
      tick(vecs[i].k, vecs[i].b, vecs[i].exp, vecs[i].nm);

    for (int i = 0; i < 3000; i++) begin
      rand_vec();
      tick(rk_v, rb_v, model(rk_v, rb_v), "random");
    end
    for (int i = 0; i < 127; i++) tick('0, '0, zexp, "drain");

    for (int i = 0; i < 60; i++) begin
      rand_vec();
      tick(rk_v, rb_v, model(rk_v, rb_v), "pre_reset");
    end
    #2;
    rst = 1'b0;
    #1;
    check("reset_async", encoded, '0);
    @(posedge clk);
    #1;
    check("reset_hold", encoded, '0);
    hist.delete();
    @(negedge clk);
    rst = 1'b1;
    tick(GK, GB, GC, "gost_after_reset");
    for (int i = 0; i < 130; i++) tick('0, '0, zexp, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
